// File: rtl/ce_init_pipeline_pkg.sv
// Shared constants and helpers for the clock-enabled INIT pipeline.
// Imported by the top level of ce_init_pipeline.
package liteeth_pipe_pkg;

  localparam logic PIPE_INIT_ONES = 1'b1;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ce_init_pipe_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit.
// Preset/reset reload INIT; a departing word leaves its data behind.
module ce_init_pipe_stage #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             preset,
  input  logic             acc,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             leave,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || preset) begin
      r_v <= 1'b0;
      r_d <= INIT;
    end else if (acc && up_valid) begin
      r_v <= 1'b1;
      r_d <= up_data;
    end else if (leave) begin
      r_v <= 1'b0;
    end
  end

  assign valid = r_v;
  assign data  = r_d;

endmodule

// File: rtl/ce_init_pipeline.sv
// DEPTH-stage handshaked pipeline with global CE and INIT preset.
// Define CE_PIPE_OCC_EN to add the registered occupancy port.
module ce_init_pipeline
  import liteeth_pipe_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{PIPE_INIT_ONES}}
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             preset,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef CE_PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0] occupancy
`endif
);

  logic             w_run;
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_acc;
  logic [DEPTH-1:0] w_leave;
  logic [DEPTH-1:0] w_up_v;
  logic [WIDTH-1:0] w_d    [DEPTH];
  logic [WIDTH-1:0] w_up_d [DEPTH];

  assign w_run = ce & ~preset;

  // Ready ripples back from the output end through every stage.
  always_comb begin
    w_acc   = '0;
    w_leave = '0;
    w_leave[DEPTH-1] = w_v[DEPTH-1] & out_ready & w_run;
    w_acc[DEPTH-1]   = w_run & (~w_v[DEPTH-1] | w_leave[DEPTH-1]);
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_leave[i] = w_v[i] & w_acc[i+1];
      w_acc[i]   = w_run & (~w_v[i] | w_leave[i]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_up_v[g] = in_valid;
      assign w_up_d[g] = in_data;
    end else begin : g_body
      assign w_up_v[g] = w_v[g-1];
      assign w_up_d[g] = w_d[g-1];
    end

    ce_init_pipe_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .preset   (preset),
      .acc      (w_acc[g]),
      .up_valid (w_up_v[g]),
      .up_data  (w_up_d[g]),
      .leave    (w_leave[g]),
      .valid    (w_v[g]),
      .data     (w_d[g])
    );
  end

  assign in_ready  = w_acc[0];
  assign out_valid = w_v[DEPTH-1] & w_run;
  assign out_data  = w_d[DEPTH-1];

`ifdef CE_PIPE_OCC_EN
  localparam int OCC_W = occ_w(DEPTH);

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OCC_W-1:0] r_occ;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || preset) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_ce_init_pipeline.sv
// Bench for ce_init_pipeline: DEPTH=3 (INIT A5) and DEPTH=1 instances
// share stimulus; a word/position model checks both every cycle.
module tb_ce_init_pipeline;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       preset = 1'b0;
  logic       ce = 1'b1;
  logic       iv = 1'b0;
  logic       ordy = 1'b0;
  logic [7:0] idata = 8'h00;

  logic       ir0, ir1, ov0, ov1;
  logic [7:0] od0, od1;
`ifdef CE_PIPE_OCC_EN
  logic [1:0] occ0;
  logic [0:0] occ1;
`endif

  always #5 clk = ~clk;

  ce_init_pipeline #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5)) dut3 (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .preset    (preset),
    .ce        (ce),
    .in_valid  (iv),
    .in_ready  (ir0),
    .in_data   (idata),
    .out_valid (ov0),
    .out_ready (ordy),
    .out_data  (od0)
`ifdef CE_PIPE_OCC_EN
    ,
    .occupancy (occ0)
`endif
  );

  ce_init_pipeline #(.WIDTH(8), .DEPTH(1)) dut1 (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .preset    (preset),
    .ce        (ce),
    .in_valid  (iv),
    .in_ready  (ir1),
    .in_data   (idata),
    .out_valid (ov1),
    .out_ready (ordy),
    .out_data  (od1)
`ifdef CE_PIPE_OCC_EN
    ,
    .occupancy (occ1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: words oldest-first, each with its stage position.
  int         dep [2];
  logic [7:0] ini [2];
  logic [7:0] wd  [2][4];
  int         wp  [2][4];
  int         cnt [2];
  logic [7:0] tail[2];
  bit         cmp_en = 0;
  int         cyc = 0;

  function automatic bit m_ir(input int k);
    return ce && !preset && (cnt[k] < dep[k] || ordy);
  endfunction

  function automatic bit m_ov(input int k);
    return ce && !preset && cnt[k] > 0 && wp[k][0] == dep[k] - 1;
  endfunction

  task automatic m_step(input int k, input bit ir);
    int prev;
    bit gone;
    if (rst || preset) begin
      cnt[k]  = 0;
      tail[k] = ini[k];
      return;
    end
    if (!ce) return;
    prev = -1;
    gone = 0;
    for (int i = 0; i < cnt[k]; i++) begin
      if (wp[k][i] == dep[k] - 1) begin
        if (ordy) begin
          gone = 1;
          prev = -1;
        end else begin
          prev = wp[k][i];
        end
      end else begin
        if (prev != wp[k][i] + 1) begin
          wp[k][i]++;
          if (wp[k][i] == dep[k] - 1) tail[k] = wd[k][i];
        end
        prev = wp[k][i];
      end
    end
    if (gone) begin
      for (int i = 1; i < cnt[k]; i++) begin
        wd[k][i-1] = wd[k][i];
        wp[k][i-1] = wp[k][i];
      end
      cnt[k]--;
    end
    if (iv && ir) begin
      wd[k][cnt[k]] = idata;
      wp[k][cnt[k]] = 0;
      if (dep[k] == 1) tail[k] = idata;
      cnt[k]++;
    end
  endtask

  // Observed transfers of the DEPTH=3 instance, for directed checks.
  int         ins_c[$];
  int         outs_c[$];
  logic [7:0] outs_d[$];

  always @(posedge clk) begin
    bit ira, irb;
    if (!rst && iv && ir0) ins_c.push_back(cyc);
    if (!rst && ov0 && ordy) begin
      outs_c.push_back(cyc);
      outs_d.push_back(od0);
    end
    ira = m_ir(0);
    irb = m_ir(1);
    m_step(0, ira);
    m_step(1, irb);
    if (rst) cmp_en = 1;
    cyc++;
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("ir3", ir0, m_ir(0));
      chk("ov3", ov0, m_ov(0));
      chk("od3", od0, tail[0]);
      chk("ir1", ir1, m_ir(1));
      chk("ov1", ov1, m_ov(1));
      chk("od1", od1, tail[1]);
`ifdef CE_PIPE_OCC_EN
      chk("occ3", occ0, cnt[0]);
      chk("occ1", occ1, cnt[1]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    bit ok;
    iv    = 1'b1;
    idata = w;
    ok    = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clk);
      ok = ir0;
      #1;
    end
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic clr();
    ins_c.delete();
    outs_c.delete();
    outs_d.delete();
  endtask

  initial begin
    dep[0] = 3;
    dep[1] = 1;
    ini[0] = 8'hA5;
    ini[1] = 8'hFF;
    cnt[0] = 0;
    cnt[1] = 0;
    tail   = ini;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ov", ov0, 0);
    chk("rst_od", od0, 8'hA5);
    chk("rst_ir", ir0, 1);
    chk("rst_od1", od1, 8'hFF);
`ifdef CE_PIPE_OCC_EN
    chk("rst_occ", occ0, 0);
`endif

    // Latency and throughput
    clr();
    ordy = 1'b1;
    for (int w = 1; w <= 16; w++) push(8'(w));
    iv = 1'b0;
    repeat (8) tick();
    chk("latency", outs_c[0] - ins_c[0], 3);
    chk("n_out", outs_d.size(), 16);
    for (int i = 0; i < 16; i++) chk("order", outs_d[i], i + 1);
    chk("burst", outs_c[15] - outs_c[0], 15);

    // Backpressure compaction
    clr();
    ordy = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    iv = 1'b0;
    @(negedge clk);
    chk("bp_ir", ir0, 0);
    chk("bp_ov", ov0, 1);
`ifdef CE_PIPE_OCC_EN
    chk("bp_occ", occ0, 3);
`endif
    tick();
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_ir_out", ir0, 1);
    chk("bp_od", od0, 8'h11);
    repeat (5) tick();
    chk("bp_n", outs_d.size(), 3);
    chk("bp_0", outs_d[0], 8'h11);
    chk("bp_1", outs_d[1], 8'h22);
    chk("bp_2", outs_d[2], 8'h33);
    chk("bp_gap", outs_c[2] - outs_c[0], 2);

    // CE freeze
    ordy = 1'b0;
    push(8'h66);
    push(8'h77);
    iv = 1'b0;
    repeat (3) tick();
    clr();
    ce    = 1'b0;
    iv    = 1'b1;
    idata = 8'h88;
    ordy  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ce_ir", ir0, 0);
      chk("ce_ov", ov0, 0);
      chk("ce_od", od0, 8'h66);
      tick();
    end
    chk("ce_nin", ins_c.size(), 0);
    chk("ce_nout", outs_d.size(), 0);
    ce = 1'b1;
    iv = 1'b0;
    repeat (6) tick();
    chk("ce_n", outs_d.size(), 2);
    chk("ce_0", outs_d[0], 8'h66);
    chk("ce_1", outs_d[1], 8'h77);

    // Preset mid-stream
    clr();
    ordy = 1'b0;
    push(8'h44);
    push(8'h55);
    iv = 1'b0;
    repeat (3) tick();
    preset = 1'b1;
    iv     = 1'b1;
    idata  = 8'h99;
    @(negedge clk);
    chk("pre_ir", ir0, 0);
    chk("pre_ov", ov0, 0);
    tick();
    preset = 1'b0;
    iv     = 1'b0;
    @(negedge clk);
    chk("post_ov", ov0, 0);
    chk("post_od", od0, 8'hA5);
    chk("post_ir", ir0, 1);
`ifdef CE_PIPE_OCC_EN
    chk("post_occ", occ0, 0);
`endif
    clr();
    ordy = 1'b1;
    push(8'hAB);
    iv = 1'b0;
    repeat (6) tick();
    chk("post_n", outs_d.size(), 1);
    chk("post_w", outs_d[0], 8'hAB);

    // Random traffic; DEPTH=1 instance checked by the model
    for (int i = 0; i < 1000; i++) begin
      iv     = 1'($urandom_range(0, 1));
      ordy   = 1'($urandom_range(0, 1));
      idata  = 8'($urandom);
      ce     = ($urandom_range(0, 9) != 0);
      preset = ($urandom_range(0, 49) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst    = 1'b0;
    preset = 1'b0;
    ce     = 1'b1;
    iv     = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
